// File: rtl/clk_rst_manager.sv
// clk_rst_manager: NCH divided clocks with per-channel tick enables and a stretched synchronous reset
// Ports: clk_100M board clock (rising edge); res synchronous active-high reset request;
//   div_load/div_val capture packed per-channel divisors; clk_out divided 50% clocks;
//   tick one-cycle enable per channel period; reset stretched downstream reset; locked running indicator.
// Optional macro CLK_STEP_MODE_EN adds step_mode/step to single-step channel 0.
module clk_rst_manager #(
  parameter int NCH         = 2,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 3,
  parameter int RST_HOLD    = 16
) (
  input  logic               clk_100M,
  input  logic               res,
  input  logic               div_load,
  input  logic [NCH*DIV_W-1:0] div_val,
`ifdef CLK_STEP_MODE_EN
  input  logic               step_mode,
  input  logic               step,
`endif
  output logic [NCH-1:0]     clk_out,
  output logic [NCH-1:0]     tick,
  output logic               reset,
  output logic               locked
);
  localparam int HW = $clog2(RST_HOLD + 1);
  logic [HW-1:0] hc, hc_nxt;
  logic frz_mode, step_edge;
  // hc saturates at RST_HOLD; reset drops on the edge where it gets there
  always_comb hc_nxt = (hc == HW'(RST_HOLD)) ? hc : hc + 1'b1;
  always_ff @(posedge clk_100M)
    if (res) begin
      hc     <= '0;
      reset  <= 1'b1;
      locked <= 1'b0;
    end else begin
      hc     <= hc_nxt;
      reset  <= hc_nxt != HW'(RST_HOLD);
      locked <= hc_nxt == HW'(RST_HOLD);
    end
`ifdef CLK_STEP_MODE_EN
  logic step_r, step_d;
  always_ff @(posedge clk_100M)
    if (res) begin
      step_r <= 1'b0;
      step_d <= 1'b0;
    end else begin
      step_r <= step;
      step_d <= step_r;
    end
  assign frz_mode  = step_mode;
  assign step_edge = step_r & ~step_d & ~reset;
`else
  assign frz_mode  = 1'b0;
  assign step_edge = 1'b0;
`endif
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [DIV_W-1:0] div_reg, cnt;
    logic clk_q, tick_q, frz, adv;
    assign frz = (i == 0) && frz_mode;
    assign adv = (i == 0) && step_edge;
    // a load restarts every channel from zero so all outputs realign without runt pulses
    always_ff @(posedge clk_100M)
      if (res || div_load) begin
        div_reg <= res ? DIV_W'(DEFAULT_DIV) : div_val[i*DIV_W +: DIV_W];
        cnt     <= '0;
        clk_q   <= 1'b0;
        tick_q  <= 1'b0;
      end else if (frz) begin
        tick_q <= adv;
        if (adv) clk_q <= ~clk_q;
      end else if (cnt == div_reg) begin
        cnt    <= '0;
        tick_q <= 1'b1;
        clk_q  <= ~clk_q;
      end else begin
        cnt    <= cnt + 1'b1;
        tick_q <= 1'b0;
      end
    assign clk_out[i] = clk_q;
    assign tick[i]    = tick_q;
  end
endmodule

// File: doc/clk_rst_manager.md
Name: clk_rst_manager

Overview:
Parametrised successor to the single-output CPU clock manager. Generates NCH independently divided clock outputs and matching one-cycle tick enables from the 100 MHz board clock. Provides a stretched, synchronous CPU reset. Sits at top level between the board oscillator/reset button and the CPU, bus, LED and segment-display logic.

Parameters:
NCH, 2, number of divider channels (1..8)
DIV_W, 8, width of each channel divisor
DEFAULT_DIV, 3, divisor loaded into every channel on reset
RST_HOLD, 16, cycles that reset stays high after res deasserts (>=1)

Ports:
clk_100M  input  1  board clock; all logic on its rising edge
res  input  1  synchronous, active-high reset
div_load  input  1  one-cycle strobe: capture div_val
div_val  input  NCH*DIV_W  packed divisors; channel i = bits [i*DIV_W +: DIV_W]
clk_out  output  NCH  divided square clocks, one bit per channel
tick  output  NCH  one-cycle enable pulse per channel period
reset  output  1  stretched synchronous reset to downstream logic
locked  output  1  high when reset is low and dividers are running

Behaviour:
- res=1 on a rising edge:
  - div_reg[i] <= DEFAULT_DIV and cnt[i] <= 0.
  - clk_out <= 0 and tick <= 0.
  - Hold counter hc <= 0; reset <= 1; locked <= 0.
- Reset stretch:
  - While res=0 and hc < RST_HOLD, hc increments each cycle.
  - When hc reaches RST_HOLD, reset <= 0 and locked <= 1 on the same edge.
  - reset therefore falls exactly RST_HOLD cycles after the first cycle with res=0. hc saturates.
- Divider channel i, active whenever res=0 (including while reset is still high):
  - If cnt[i]==div_reg[i]: cnt[i] <= 0, tick[i] <= 1, clk_out[i] <= ~clk_out[i].
  - Otherwise: cnt[i] <= cnt[i]+1 and tick[i] <= 0.
  - tick period = div+1 cycles. clk_out period = 2*(div+1) cycles, 50% duty.
  - div=0: tick is constantly 1 and clk_out toggles every cycle (clk/2).
  - Maximum divisor 2^DIV_W-1; no overflow possible.
- The first tick after reset occurs on the (div+1)th cycle with res=0. The first clk_out rise is on that same edge.
- div_load=1 with res=0:
  - div_reg <= div_val and all cnt <= 0.
  - All clk_out <= 0 and tick <= 0 (synchronised restart, no runt pulses).
  - locked and reset are unchanged.
- div_load while res=1: ignored (res wins).
- Reset mid-operation: res asserted at any point immediately restores all reset values on that edge. Stretch restarts from 0.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
Macro: CLK_STEP_MODE_EN
- Defined:
  - Adds inputs step_mode (1) and step (1), which is debounced externally.
  - step is registered with an internal edge detector.
  - While step_mode=1, channel 0's counter is frozen and tick[0] is 0, except on a detected 0->1 edge of step: tick[0]=1 for exactly one cycle and clk_out[0] toggles.
  - Leaving step mode resumes counting from the frozen cnt[0].
  - Other channels are unaffected.
  - step edges while reset=1 are ignored.
- Not defined: ports absent; channel 0 free-runs as above.

Test Plan:
- Reset value check: hold res=1 for 5 cycles -> reset=1, locked=0, clk_out=0, tick=0 throughout.
- Stretch timing, RST_HOLD=16: release res -> reset falls and locked rises exactly 16 cycles after release. Assert res again mid-stretch at cycle 8 -> reset stays 1 and a full 16-cycle stretch follows the next release.
- Default divide, DEFAULT_DIV=3: tick[0] pulses every 4 cycles; clk_out[0] has period 8 with 4 high and 4 low; first tick is 4 cycles after res falls.
- Runtime load: div_load with ch0=0, ch1=9 -> next cycle all clk_out=0. Then tick[0] is high every cycle and clk_out[0] toggles each cycle. tick[1] is every 10 cycles and clk_out[1] has period 20. locked stays 1.
- Simultaneous events: res=1 and div_load=1 on the same edge -> divisors equal DEFAULT_DIV (3) and load is ignored. div=255 with DIV_W=8 -> tick period 256, no wrap glitch.
- CLK_STEP_MODE_EN: step_mode=1, three step pulses spaced 20 cycles apart -> exactly three tick[0] pulses and clk_out[0] toggles 0->1->0->1. Channel 1 keeps its normal period. A step pulse while reset=1 produces no tick.
